// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one memory request per FETCH
// phase and holds the fetched word stable on instr_raw for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  state,
  input  logic        pc_we,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr_raw,
  output logic [31:0] pc,
  output logic        fetch_done,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } fetch_state_t;

  localparam logic [2:0] PHASE_FETCH = 3'd0;

  fetch_state_t fsm_q;
  logic         imem_req_q;
  logic [31:0]  imem_addr_q;
  logic [31:0]  instr_raw_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         fetch_done_q;
  logic         misaligned_q;
  logic         misaligned_d;

  // PC commit is independent of the fetch FSM so it may land mid-fetch.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (pc_we) begin
      if (branch_taken) begin
        pc_d = {branch_target[31:2], 2'b00};
        if (branch_target[1:0] != 2'b00) begin
          misaligned_d = 1'b1;
        end
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= S_IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= 32'h0000_0000;
      instr_raw_q  <= NOP_INSTR;
      pc_q         <= RESET_PC;
      fetch_done_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      fetch_done_q <= 1'b0;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      case (fsm_q)
        S_IDLE: begin
          if (state == PHASE_FETCH) begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= pc_q;
            fsm_q       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ready) begin
            instr_raw_q  <= imem_rdata;
            fetch_done_q <= 1'b1;
            imem_req_q   <= 1'b0;
            fsm_q        <= S_DONE;
          end
        end
        // Only leaving FETCH re-arms the fetcher, so one request per phase.
        S_DONE: begin
          if (state != PHASE_FETCH) begin
            fsm_q <= S_IDLE;
          end
        end
        default: begin
          fsm_q      <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign instr_raw  = instr_raw_q;
  assign pc         = pc_q;
  assign fetch_done = fetch_done_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential fetch, memory
// stalls, branches, PC wrap, single fetch per phase and reset mid-fetch.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  state;
  logic        pc_we;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr_raw;
  logic [31:0] pc;
  logic        fetch_done;
  logic        misaligned;

  int vectors;
  int miscompares;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .state         (state),
    .pc_we         (pc_we),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .instr_raw     (instr_raw),
    .pc            (pc),
    .fetch_done    (fetch_done),
    .misaligned    (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'hA500_0000 ^ addr;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] st, input logic we,
                               input logic taken, input logic [31:0] target,
                               input logic ready, input logic [31:0] rdata);
    state         = st;
    pc_we         = we;
    branch_taken  = taken;
    branch_target = target;
    imem_ready    = ready;
    imem_rdata    = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req"},   32'(imem_req),   32'h0);
    checkOutput({tag, "_addr"},  imem_addr,       32'h0);
    checkOutput({tag, "_instr"}, instr_raw,       32'h0000_0013);
    checkOutput({tag, "_pc"},    pc,              32'h0);
    checkOutput({tag, "_done"},  32'(fetch_done), 32'h0);
    checkOutput({tag, "_mis"},   32'(misaligned), 32'h0);
  endtask

  initial begin
    logic [31:0] expPc;
    int reqCount;
    int doneCount;
    logic prevReq;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(3'd1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) step();
    checkResetValues("reset");
    rst_n = 1'b1;

    // Sequential loop through all phases, zero-wait memory.
    for (int i = 0; i < 3; i++) begin
      expPc = 32'(i * 4);
      applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      checkOutput("seq_req", 32'(imem_req), 32'h1);
      checkOutput("seq_addr", imem_addr, expPc);
      applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 1'b1, memWord(expPc));
      step();
      checkOutput("seq_done", 32'(fetch_done), 32'h1);
      checkOutput("seq_instr", instr_raw, memWord(expPc));
      checkOutput("seq_req_low", 32'(imem_req), 32'h0);
      checkOutput("seq_pc", pc, expPc);
      for (int s = 1; s <= 4; s++) begin
        applyStimulus(3'(s), (s == 4), 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        if (s == 1) checkOutput("seq_done_pulse", 32'(fetch_done), 32'h0);
      end
      checkOutput("seq_pc_next", pc, expPc + 32'd4);
    end

    // Five-cycle stall with a misaligned branch committed mid-WAIT.
    applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("stall_req0", 32'(imem_req), 32'h1);
    checkOutput("stall_addr0", imem_addr, 32'h0000_000C);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) applyStimulus(3'd0, 1'b1, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
      else        applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      checkOutput("stall_req", 32'(imem_req), 32'h1);
      checkOutput("stall_addr", imem_addr, 32'h0000_000C);
      checkOutput("stall_done", 32'(fetch_done), 32'h0);
      checkOutput("stall_instr", instr_raw, memWord(32'h8));
    end
    checkOutput("br_pc", pc, 32'h0000_0100);
    checkOutput("br_mis", 32'(misaligned), 32'h1);
    applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 1'b1, memWord(32'hC));
    step();
    checkOutput("stall_fin_done", 32'(fetch_done), 32'h1);
    checkOutput("stall_fin_instr", instr_raw, memWord(32'hC));
    checkOutput("stall_fin_req", 32'(imem_req), 32'h0);

    // Aligned branch keeps the sticky flag; then wrap past the top.
    applyStimulus(3'd1, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    step();
    checkOutput("br2_pc", pc, 32'h0000_0200);
    checkOutput("br2_mis", 32'(misaligned), 32'h1);
    checkOutput("br2_done", 32'(fetch_done), 32'h0);
    applyStimulus(3'd2, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step();
    checkOutput("top_pc", pc, 32'hFFFF_FFFC);
    applyStimulus(3'd3, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("wrap_pc", pc, 32'h0000_0000);

    // FETCH held for ten cycles, with a stray response while in DONE.
    reqCount  = 0;
    doneCount = 0;
    prevReq   = imem_req;
    for (int i = 0; i < 10; i++) begin
      if (i == 1)      applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 1'b1, memWord(32'h0));
      else if (i == 5) applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      else             applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      if (imem_req && !prevReq) reqCount++;
      if (fetch_done) doneCount++;
      prevReq = imem_req;
      if (i == 0) checkOutput("hold_addr", imem_addr, 32'h0);
    end
    checkOutput("hold_reqs", 32'(reqCount), 32'd1);
    checkOutput("hold_dones", 32'(doneCount), 32'd1);
    checkOutput("hold_instr", instr_raw, memWord(32'h0));
    checkOutput("hold_req_low", 32'(imem_req), 32'h0);

    // Reset asserted asynchronously while a fetch is outstanding.
    applyStimulus(3'd1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("rw_req", 32'(imem_req), 32'h1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_rst");
    step();
    rst_n = 1'b1;
    applyStimulus(3'd1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D);
    step();
    checkResetValues("post_rst");
    applyStimulus(3'd1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("post_rst_done", 32'(fetch_done), 32'h0);
    checkOutput("post_rst_instr", instr_raw, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
